// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared widths, types, FSM states and screen defaults for the pong engine
package pong_pkg;

    localparam int X_W          = 10;
    localparam int Y_W          = 9;
    localparam int CALC_W       = 12;
    localparam int VEL_W        = 6;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    typedef logic signed [CALC_W-1:0] coord_t;
    typedef logic signed [VEL_W-1:0]  vel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PADDLES,
        ST_BALL,
        ST_COLLIDE,
        ST_WALLS,
        ST_COMMIT
    } state_t;

    function automatic coord_t abs_c(input coord_t v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic vel_t abs_v(input vel_t v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic coord_t widen_x(input logic [X_W-1:0] v);
        return coord_t'({{(CALC_W-X_W){1'b0}}, v});
    endfunction

    function automatic coord_t widen_y(input logic [Y_W-1:0] v);
        return coord_t'({{(CALC_W-Y_W){1'b0}}, v});
    endfunction

endpackage

// File: rtl/pong_paddle_step.sv
// rtl/pong_paddle_step.sv - one-frame move and clamp of a single paddle; PONG_SPIN_EN exposes the y-move sign
module pong_paddle_step
    import pong_pkg::*;
#(
    parameter int SCREEN_W     = DEF_SCREEN_W,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int PAD_HW       = 25,
    parameter int PAD_HH       = 33,
    parameter int PADDLE_SPEED = 2,
    parameter bit RIGHT_SIDE   = 1'b0
)(
    input  logic [X_W-1:0] cur_x,
    input  logic [Y_W-1:0] cur_y,
    input  logic           up,
    input  logic           down,
    input  logic           left,
    input  logic           right,
    output logic [X_W-1:0] next_x,
    output logic [Y_W-1:0] next_y
`ifdef PONG_SPIN_EN
    ,
    output logic signed [1:0] dy_sign
`endif
);

    // each side is confined to its own half of the court
    localparam coord_t LO_X = coord_t'(RIGHT_SIDE ? SCREEN_W/2 + PAD_HW : PAD_HW);
    localparam coord_t HI_X = coord_t'(RIGHT_SIDE ? SCREEN_W - 1 - PAD_HW : SCREEN_W/2 - 1 - PAD_HW);
    localparam coord_t LO_Y = coord_t'(PAD_HH);
    localparam coord_t HI_Y = coord_t'(SCREEN_H - 1 - PAD_HH);
    localparam coord_t SPD  = coord_t'(PADDLE_SPEED);

    coord_t x_s, y_s, x_m, y_m;

    always_comb begin
        x_s = widen_x(cur_x);
        y_s = widen_y(cur_y);
        x_m = x_s;
        y_m = y_s;
        if (right && !left)
            x_m = x_s + SPD;
        else if (left && !right)
            x_m = x_s - SPD;
        if (down && !up)
            y_m = y_s + SPD;
        else if (up && !down)
            y_m = y_s - SPD;
        if (x_m < LO_X)
            x_m = LO_X;
        else if (x_m > HI_X)
            x_m = HI_X;
        if (y_m < LO_Y)
            y_m = LO_Y;
        else if (y_m > HI_Y)
            y_m = HI_Y;
    end

    assign next_x = x_m[X_W-1:0];
    assign next_y = y_m[Y_W-1:0];

`ifdef PONG_SPIN_EN
    assign dy_sign = (y_m > y_s) ? 2'sd1 : ((y_m < y_s) ? -2'sd1 : 2'sd0);
`endif

endmodule

// File: rtl/pong_engine.sv
// rtl/pong_engine.sv - frame-tick pong game-state engine with atomic commit; PONG_SPIN_EN adds paddle spin
module pong_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W         = DEF_SCREEN_W,
    parameter int SCREEN_H         = DEF_SCREEN_H,
    parameter int PADDLES_PER_SIDE = 1,
    parameter int PAD_HW           = 25,
    parameter int PAD_HH           = 33,
    parameter int BALL_HW          = 10,
    parameter int BALL_HH          = 15,
    parameter int PADDLE_SPEED     = 2,
    parameter int BALL_SPEED       = 2,
    parameter int MAX_VY           = 4,
    parameter int HOME_X           = 80,
    parameter int LANE_GAP         = 120,
    parameter int GOAL_HALF_H      = 40,
    parameter int SERVE_FRAMES     = 60,
    parameter int SCORE_W          = 4
)(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                frame_tick,
    input  logic [2*PADDLES_PER_SIDE-1:0]       btn_up,
    input  logic [2*PADDLES_PER_SIDE-1:0]       btn_down,
    input  logic [2*PADDLES_PER_SIDE-1:0]       btn_left,
    input  logic [2*PADDLES_PER_SIDE-1:0]       btn_right,
    output logic [2*PADDLES_PER_SIDE*X_W-1:0]   pad_x,
    output logic [2*PADDLES_PER_SIDE*Y_W-1:0]   pad_y,
    output logic [X_W-1:0]                      ball_x,
    output logic [Y_W-1:0]                      ball_y,
    output logic [SCORE_W-1:0]                  score_l,
    output logic [SCORE_W-1:0]                  score_r,
    output logic                                goal_l,
    output logic                                goal_r,
    output logic                                busy,
    output logic                                update_done
);

    localparam int     NP         = 2*PADDLES_PER_SIDE;
    localparam int     IDX_W      = $clog2(NP);
    localparam int     SERVE_W    = $clog2(SERVE_FRAMES + 1);
    localparam coord_t HIT_DX     = coord_t'(BALL_HW + PAD_HW);
    localparam coord_t HIT_DY     = coord_t'(BALL_HH + PAD_HH);
    localparam coord_t C_BALL_HW  = coord_t'(BALL_HW);
    localparam coord_t C_BALL_HH  = coord_t'(BALL_HH);
    localparam coord_t BOTTOM_LIM = coord_t'(SCREEN_H - 1);
    localparam coord_t RIGHT_LIM  = coord_t'(SCREEN_W - 1);
    localparam coord_t MID_X      = coord_t'(SCREEN_W/2);
    localparam coord_t MID_Y      = coord_t'(SCREEN_H/2);
    localparam coord_t GOAL_H     = coord_t'(GOAL_HALF_H);
    localparam vel_t   SPEED      = vel_t'(BALL_SPEED);
    localparam vel_t   MAX_V      = vel_t'(MAX_VY);

    state_t state, state_nxt;

    logic [IDX_W-1:0]   coll_idx;
    logic [SERVE_W-1:0] serve_cnt;
    logic [X_W-1:0]     pad_x_q [NP];
    logic [Y_W-1:0]     pad_y_q [NP];
    logic [X_W-1:0]     sh_px   [NP];
    logic [Y_W-1:0]     sh_py   [NP];
    logic [X_W-1:0]     step_x  [NP];
    logic [Y_W-1:0]     step_y  [NP];
    coord_t             sh_bx, sh_by;
    vel_t               vx_q, vy_q, sh_vx, sh_vy;
`ifdef PONG_SPIN_EN
    logic signed [1:0]  step_dy [NP];
    logic signed [1:0]  sh_dy   [NP];
`endif

    function automatic logic [X_W-1:0] home_x(input int p);
        int k;
        k = p / 2;
        return (p % 2 == 0) ? X_W'(HOME_X + k*LANE_GAP) : X_W'(SCREEN_W - HOME_X - k*LANE_GAP);
    endfunction

    generate
        for (genvar p = 0; p < NP; p++) begin : g_pad
            pong_paddle_step #(
                .SCREEN_W     (SCREEN_W),
                .SCREEN_H     (SCREEN_H),
                .PAD_HW       (PAD_HW),
                .PAD_HH       (PAD_HH),
                .PADDLE_SPEED (PADDLE_SPEED),
                .RIGHT_SIDE   (p % 2 == 1)
            ) u_step (
                .cur_x   (pad_x_q[p]),
                .cur_y   (pad_y_q[p]),
                .up      (btn_up[p]),
                .down    (btn_down[p]),
                .left    (btn_left[p]),
                .right   (btn_right[p]),
                .next_x  (step_x[p]),
                .next_y  (step_y[p])
`ifdef PONG_SPIN_EN
                ,
                .dy_sign (step_dy[p])
`endif
            );
            assign pad_x[p*X_W +: X_W] = pad_x_q[p];
            assign pad_y[p*Y_W +: Y_W] = pad_y_q[p];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (frame_tick) state_nxt = ST_PADDLES;
            ST_PADDLES: state_nxt = ST_BALL;
            ST_BALL:    state_nxt = ST_COLLIDE;
            ST_COLLIDE: if (coll_idx == IDX_W'(NP-1)) state_nxt = ST_WALLS;
            ST_WALLS:   state_nxt = ST_COMMIT;
            ST_COMMIT:  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    assign busy        = (state != ST_IDLE);
    assign update_done = (state == ST_COMMIT);

    coord_t px_sel, py_sel;
    logic   hit;
    vel_t   hit_vx, hit_vy;

    // sign is forced, not flipped, so a ball still overlapping next frame cannot oscillate
    always_comb begin
        px_sel = widen_x(sh_px[coll_idx]);
        py_sel = widen_y(sh_py[coll_idx]);
        hit    = (abs_c(sh_bx - px_sel) < HIT_DX) && (abs_c(sh_by - py_sel) < HIT_DY);
        hit_vx = coll_idx[0] ? -abs_v(sh_vx) : abs_v(sh_vx);
`ifdef PONG_SPIN_EN
        hit_vy = sh_vy + vel_t'(sh_dy[coll_idx]);
`else
        hit_vy = sh_vy;
`endif
        if (hit_vy > MAX_V)
            hit_vy = MAX_V;
        else if (hit_vy < -MAX_V)
            hit_vy = -MAX_V;
    end

    coord_t w_bx, w_by;
    vel_t   w_vx, w_vy;
    logic   w_goal_l, w_goal_r;

    always_comb begin
        w_bx     = sh_bx;
        w_by     = sh_by;
        w_vx     = sh_vx;
        w_vy     = sh_vy;
        w_goal_l = 1'b0;
        w_goal_r = 1'b0;
        if (sh_by - C_BALL_HH <= 0) begin
            w_by = C_BALL_HH;
            w_vy = abs_v(sh_vy);
        end else if (sh_by + C_BALL_HH >= BOTTOM_LIM) begin
            w_by = BOTTOM_LIM - C_BALL_HH;
            w_vy = -abs_v(sh_vy);
        end
        if (sh_bx + C_BALL_HW >= RIGHT_LIM) begin
            if (abs_c(w_by - MID_Y) < GOAL_H) begin
                w_goal_l = 1'b1;
            end else begin
                w_bx = RIGHT_LIM - C_BALL_HW;
                w_vx = -abs_v(sh_vx);
            end
        end else if (sh_bx - C_BALL_HW <= 0) begin
            if (abs_c(w_by - MID_Y) < GOAL_H) begin
                w_goal_r = 1'b1;
            end else begin
                w_bx = C_BALL_HW;
                w_vx = abs_v(sh_vx);
            end
        end
        // serve heads toward the side that just conceded
        if (w_goal_l || w_goal_r) begin
            w_bx = MID_X;
            w_by = MID_Y;
            w_vx = w_goal_l ? SPEED : -SPEED;
            w_vy = SPEED;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                pad_x_q[p] <= home_x(p);
                pad_y_q[p] <= Y_W'(SCREEN_H/2);
                sh_px[p]   <= home_x(p);
                sh_py[p]   <= Y_W'(SCREEN_H/2);
`ifdef PONG_SPIN_EN
                sh_dy[p]   <= 2'sd0;
`endif
            end
            ball_x    <= X_W'(SCREEN_W/2);
            ball_y    <= Y_W'(SCREEN_H/2);
            vx_q      <= SPEED;
            vy_q      <= SPEED;
            sh_bx     <= MID_X;
            sh_by     <= MID_Y;
            sh_vx     <= SPEED;
            sh_vy     <= SPEED;
            score_l   <= '0;
            score_r   <= '0;
            serve_cnt <= '0;
            coll_idx  <= '0;
            goal_l    <= 1'b0;
            goal_r    <= 1'b0;
        end else begin
            goal_l <= 1'b0;
            goal_r <= 1'b0;
            case (state)
                ST_PADDLES: begin
                    for (int p = 0; p < NP; p++) begin
                        sh_px[p] <= step_x[p];
                        sh_py[p] <= step_y[p];
`ifdef PONG_SPIN_EN
                        sh_dy[p] <= step_dy[p];
`endif
                    end
                    sh_bx    <= widen_x(ball_x);
                    sh_by    <= widen_y(ball_y);
                    sh_vx    <= vx_q;
                    sh_vy    <= vy_q;
                    coll_idx <= '0;
                end
                ST_BALL: begin
                    if (serve_cnt != '0) begin
                        serve_cnt <= serve_cnt - 1'b1;
                    end else begin
                        sh_bx <= sh_bx + coord_t'(sh_vx);
                        sh_by <= sh_by + coord_t'(sh_vy);
                    end
                end
                ST_COLLIDE: begin
                    if (hit) begin
                        sh_vx <= hit_vx;
                        sh_vy <= hit_vy;
                    end
                    coll_idx <= coll_idx + 1'b1;
                end
                ST_WALLS: begin
                    for (int p = 0; p < NP; p++) begin
                        pad_x_q[p] <= sh_px[p];
                        pad_y_q[p] <= sh_py[p];
                    end
                    ball_x <= w_bx[X_W-1:0];
                    ball_y <= w_by[Y_W-1:0];
                    vx_q   <= w_vx;
                    vy_q   <= w_vy;
                    goal_l <= w_goal_l;
                    goal_r <= w_goal_r;
                    if (w_goal_l && score_l != {SCORE_W{1'b1}})
                        score_l <= score_l + 1'b1;
                    if (w_goal_r && score_r != {SCORE_W{1'b1}})
                        score_r <= score_r + 1'b1;
                    if (w_goal_l || w_goal_r)
                        serve_cnt <= SERVE_W'(SERVE_FRAMES);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_engine.sv
// tb/tb_pong_engine.sv - self-checking bench for pong_engine against a frame-level game model
module tb_pong_engine;

    localparam int NP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          frame_tick;
    logic [NP-1:0] btn_up, btn_down, btn_left, btn_right;

    logic [NP*10-1:0] pad_x0, pad_x1;
    logic [NP*9-1:0]  pad_y0, pad_y1;
    logic [9:0]       ball_x0, ball_x1;
    logic [8:0]       ball_y0, ball_y1;
    logic [3:0]       score_l0, score_l1, score_r0, score_r1;
    logic             goal_l0, goal_l1, goal_r0, goal_r1;
    logic             busy0, busy1, done0, done1;

    pong_engine dut0 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .pad_x(pad_x0), .pad_y(pad_y0), .ball_x(ball_x0), .ball_y(ball_y0),
        .score_l(score_l0), .score_r(score_r0), .goal_l(goal_l0), .goal_r(goal_r0),
        .busy(busy0), .update_done(done0)
    );

    pong_engine #(.GOAL_HALF_H(240)) dut1 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .pad_x(pad_x1), .pad_y(pad_y1), .ball_x(ball_x1), .ball_y(ball_y1),
        .score_l(score_l1), .score_r(score_r1), .goal_l(goal_l1), .goal_r(goal_r1),
        .busy(busy1), .update_done(done1)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // game model: index 0 = default goal mouth, index 1 = goal mouth spanning the whole wall
    int m_px [2][NP];
    int m_py [2][NP];
    int m_bx [2], m_by [2], m_vx [2], m_vy [2];
    int m_sl [2], m_sr [2], m_serve [2];
    bit m_gl [2], m_gr [2];
    bit exp_busy, exp_done;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic check(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (dut%0d): got %0d, expected %0d at %0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_px[i][0] = 80;  m_py[i][0] = 240;
            m_px[i][1] = 560; m_py[i][1] = 240;
            m_bx[i] = 320; m_by[i] = 240; m_vx[i] = 2; m_vy[i] = 2;
            m_sl[i] = 0; m_sr[i] = 0; m_serve[i] = 0;
            m_gl[i] = 0; m_gr[i] = 0;
        end
        exp_busy = 0;
        exp_done = 0;
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int gh;
            gh = (i == 0) ? 40 : 240;
            m_gl[i] = 0;
            m_gr[i] = 0;
            for (int p = 0; p < NP; p++) begin
                int dx, dy;
                dx = 0; dy = 0;
                if (btn_up[p] && !btn_down[p]) dy = -2;
                else if (btn_down[p] && !btn_up[p]) dy = 2;
                if (btn_left[p] && !btn_right[p]) dx = -2;
                else if (btn_right[p] && !btn_left[p]) dx = 2;
                m_py[i][p] = clampi(m_py[i][p] + dy, 33, 446);
                if (p % 2 == 0) m_px[i][p] = clampi(m_px[i][p] + dx, 25, 294);
                else            m_px[i][p] = clampi(m_px[i][p] + dx, 345, 614);
            end
            if (m_serve[i] > 0) m_serve[i]--;
            else begin
                m_bx[i] += m_vx[i];
                m_by[i] += m_vy[i];
            end
            for (int p = 0; p < NP; p++)
                if (iabs(m_bx[i] - m_px[i][p]) < 35 && iabs(m_by[i] - m_py[i][p]) < 48)
                    m_vx[i] = (p % 2 == 0) ? iabs(m_vx[i]) : -iabs(m_vx[i]);
            if (m_by[i] - 15 <= 0) begin m_by[i] = 15; m_vy[i] = iabs(m_vy[i]); end
            if (m_by[i] + 15 >= 479) begin m_by[i] = 464; m_vy[i] = -iabs(m_vy[i]); end
            if (m_bx[i] + 10 >= 639) begin
                if (iabs(m_by[i] - 240) < gh) m_gl[i] = 1;
                else begin m_bx[i] = 629; m_vx[i] = -iabs(m_vx[i]); end
            end else if (m_bx[i] - 10 <= 0) begin
                if (iabs(m_by[i] - 240) < gh) m_gr[i] = 1;
                else begin m_bx[i] = 10; m_vx[i] = iabs(m_vx[i]); end
            end
            if (m_gl[i]) m_sl[i] = (m_sl[i] < 15) ? m_sl[i] + 1 : 15;
            if (m_gr[i]) m_sr[i] = (m_sr[i] < 15) ? m_sr[i] + 1 : 15;
            if (m_gl[i] || m_gr[i]) begin
                m_bx[i] = 320; m_by[i] = 240;
                m_vx[i] = m_gl[i] ? 2 : -2;
                m_vy[i] = 2;
                m_serve[i] = 60;
            end
        end
    endtask

    task automatic cmp_inst(input int i, input logic [NP*10-1:0] px, input logic [NP*9-1:0] py,
                            input logic [9:0] bx, input logic [8:0] by,
                            input logic [3:0] sl, input logic [3:0] sr,
                            input logic gl, input logic gr, input logic bz, input logic dn);
        for (int p = 0; p < NP; p++) begin
            check("pad_x", i, int'(px[p*10 +: 10]), m_px[i][p]);
            check("pad_y", i, int'(py[p*9 +: 9]), m_py[i][p]);
        end
        check("ball_x", i, int'(bx), m_bx[i]);
        check("ball_y", i, int'(by), m_by[i]);
        check("score_l", i, int'(sl), m_sl[i]);
        check("score_r", i, int'(sr), m_sr[i]);
        check("goal_l", i, int'(gl), (exp_done && m_gl[i]) ? 1 : 0);
        check("goal_r", i, int'(gr), (exp_done && m_gr[i]) ? 1 : 0);
        check("busy", i, int'(bz), int'(exp_busy));
        check("update_done", i, int'(dn), int'(exp_done));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_inst(0, pad_x0, pad_y0, ball_x0, ball_y0, score_l0, score_r0, goal_l0, goal_r0, busy0, done0);
            cmp_inst(1, pad_x1, pad_y1, ball_x1, ball_y1, score_l1, score_r1, goal_l1, goal_r1, busy1, done1);
        end
    end

    // one frame: tick, optional extra tick while busy, then the commit cycle
    task automatic frame(input bit glitch);
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0; exp_busy = 1;
        if (glitch) begin
            @(posedge clk); #1 frame_tick = 1'b1;
            @(posedge clk); #1 frame_tick = 1'b0;
            repeat (NP + 1) @(posedge clk);
        end else begin
            repeat (NP + 3) @(posedge clk);
        end
        #1 model_step(); exp_done = 1;
        @(posedge clk); #1 exp_done = 0; exp_busy = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b0; frame_tick = 1'b0;
        btn_up = '0; btn_down = '0; btn_left = '0; btn_right = '0;
        @(posedge clk); #1 model_reset(); reset = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; frame_tick = 1'b0;
        btn_up = '0; btn_down = '0; btn_left = '0; btn_right = '0;
        repeat (2) @(posedge clk);
        #1 model_reset(); reset = 1'b1; cmp_en = 1'b1;

        check("rst_pad_x0", 0, int'(pad_x0[9:0]), 80);
        check("rst_pad_x1", 0, int'(pad_x0[19:10]), 560);
        check("rst_pad_y0", 0, int'(pad_y0[8:0]), 240);
        check("rst_pad_y1", 0, int'(pad_y0[17:9]), 240);
        check("rst_ball_x", 0, int'(ball_x0), 320);
        check("rst_ball_y", 0, int'(ball_y0), 240);
        check("rst_score_l", 0, int'(score_l0), 0);
        check("rst_busy", 0, int'(busy0), 0);

        for (int n = 1; n <= 216; n++) begin
            frame(n >= 150 && n <= 160);
            if (n == 112) begin
                check("lit_ball_x_112", 0, int'(ball_x0), 544);
                check("lit_ball_y_112", 0, int'(ball_y0), 464);
            end
            if (n == 113) begin
                check("lit_ball_x_113", 0, int'(ball_x0), 546);
                check("lit_ball_y_113", 0, int'(ball_y0), 462);
            end
            if (n == 155) begin
                check("lit_bounce_x", 0, int'(ball_x0), 629);
                check("lit_bounce_y", 0, int'(ball_y0), 378);
                check("lit_no_goal", 0, int'(score_l0), 0);
                check("lit_goal_score", 1, int'(score_l1), 1);
                check("lit_goal_bx", 1, int'(ball_x1), 320);
                check("lit_goal_by", 1, int'(ball_y1), 240);
            end
            if (n == 215) check("lit_serve_hold", 1, int'(ball_x1), 320);
            if (n == 216) begin
                check("lit_serve_go_x", 1, int'(ball_x1), 322);
                check("lit_serve_go_y", 1, int'(ball_y1), 242);
            end
        end

        do_reset();
        for (int n = 1; n <= 104; n++) begin
            btn_down[1] = (n <= 90);
            frame(1'b0);
            if (n == 103) begin
                check("lit_hit_bx", 0, int'(ball_x0), 526);
                check("lit_hit_by", 0, int'(ball_y0), 446);
            end
            if (n == 104) begin
                check("lit_after_hit_bx", 0, int'(ball_x0), 524);
                check("lit_pad1_y", 0, int'(pad_y0[17:9]), 420);
            end
        end

        do_reset();
        btn_up[0] = 1'b1; btn_right[0] = 1'b1; btn_left[1] = 1'b1;
        for (int n = 1; n <= 300; n++) frame(1'b0);
        check("lit_pad0_ymin", 0, int'(pad_y0[8:0]), 33);
        check("lit_pad0_xmax", 0, int'(pad_x0[9:0]), 294);
        check("lit_pad1_xmin", 0, int'(pad_x0[19:10]), 345);
        btn_down[0] = 1'b1; btn_left[0] = 1'b1;
        for (int n = 1; n <= 5; n++) frame(1'b0);
        check("lit_updown_hold", 0, int'(pad_y0[8:0]), 33);
        check("lit_leftright_hold", 0, int'(pad_x0[9:0]), 294);

        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0; exp_busy = 1;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 model_reset(); reset = 1'b1;
        btn_up = '0; btn_down = '0; btn_left = '0; btn_right = '0;
        check("lit_midreset_busy", 0, int'(busy0), 0);
        check("lit_midreset_pad_y", 0, int'(pad_y0[8:0]), 240);
        check("lit_midreset_ball_x", 0, int'(ball_x0), 320);
        repeat (3) @(posedge clk);
        frame(1'b0);
        check("lit_post_reset_frame", 0, int'(ball_x0), 322);

        @(posedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
